arbitro_stampa_carattere: RTL

Round-robin controller that shares the character-print I/O interface (the port at address 16'h0000 that prints `d7_d0` when selected and `iow_` falls) among several requesters. It grants one requester at a time, latches its character, and then generates a timed bus write: address/data setup, an `iow_` low strobe, and a hold phase. It sits between the character sources (CPU-side sequencer, debug/trace units) and the IO block's `a15_a0` / `d7_d0` / `iow_` inputs.

---
 rtl/arbitro_stampa_carattere.sv | 117 +++++++++++
 1 files changed

// File: rtl/arbitro_stampa_carattere.sv
// Round-robin arbiter that shares the character-print port among N_REQ sources
// and drives a timed setup / iow_ strobe / hold write cycle for each character.
module arbitro_stampa_carattere #(
    parameter int N_REQ  = 4,
    parameter int SETUP  = 1,
    parameter int STROBE = 2,
    parameter int HOLD   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] char_in,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [15:0]        a15_a0,
    output logic [7:0]         d7_d0,
    output logic               iow_,
    output logic [15:0]        chars_sent
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t         state;
    logic [7:0]     phase;
    logic [IW-1:0]  last;
    logic [IW-1:0]  pick;
    logic           found;

    // Scan downward in distance so the nearest requester after last wins.
    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[IW'(j)]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= '0;
            last       <= IW'(N_REQ - 1);
            ack        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            a15_a0     <= 16'hFFFF;
            d7_d0      <= 8'h00;
            iow_       <= 1'b1;
            chars_sent <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant  <= N_REQ'(1) << pick;
                        d7_d0  <= char_in[8*pick +: 8];
                        a15_a0 <= 16'h0000;
                        busy   <= 1'b1;
                        phase  <= 8'(SETUP - 1);
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase == 8'd0) begin
                        iow_  <= 1'b0;
                        phase <= 8'(STROBE - 1);
                        state <= S_STROBE;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (phase == 8'd0) begin
                        iow_  <= 1'b1;
                        phase <= 8'(HOLD - 1);
                        state <= S_HOLD;
                        if (HOLD == 1) ack <= grant;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (phase == 8'd0) begin
                        for (int k = 0; k < N_REQ; k++)
                            if (grant[k]) last <= IW'(k);
                        grant      <= '0;
                        busy       <= 1'b0;
                        a15_a0     <= 16'hFFFF;
                        d7_d0      <= 8'h00;
                        chars_sent <= chars_sent + 16'd1;
                        state      <= S_IDLE;
                    end else begin
                        phase <= phase - 8'd1;
                        if (phase == 8'd1) ack <= grant;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
